// File: rtl/card_dealer.sv
// card_dealer: deals cards from one 52-card deck without repetition.
// Each request draws a card index from the LFSR word by rejection sampling.
// If MAX_TRIES draws all miss, a bounded linear probe over the dealt-card
// bitmap finds the card instead.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   rand_in[31:0]     LFSR word, only bits [5:0] are used
//   shuffle           return all cards to the deck (IDLE only)
//   deal_req          request one card (IDLE only)
//   deal_ready        high while IDLE
//   card_valid        one-cycle pulse when a new card is presented
//   card_idx/rank/suit  last dealt card, held until the next deal
//   cards_left        undealt card count 0..52
//   deck_empty        cards_left == 0
//   deal_err          one-cycle pulse for a deal request on an empty deck
module card_dealer #(
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rand_in,
    input  logic        shuffle,
    input  logic        deal_req,
    output logic        deal_ready,
    output logic        card_valid,
    output logic [5:0]  card_idx,
    output logic [3:0]  card_rank,
    output logic [1:0]  card_suit,
    output logic [5:0]  cards_left,
    output logic        deck_empty,
    output logic        deal_err
);

    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned TRY_W     = 6;
    localparam int unsigned PAD_W     = 64 - DECK_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_PROBE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DECK_SIZE-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]     left_q, left_d;
    logic [TRY_W-1:0]     tries_q, tries_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [3:0]           rank_q, rank_d;
    logic [1:0]           suit_q, suit_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 ready_q, ready_d;
    logic                 empty_q, empty_d;

    // Padded view of the mask: indices 52..63 read as taken, so a single
    // bit test rejects both out-of-range and already-dealt candidates.
    logic [63:0]          mask_pad;
    logic [IDX_W-1:0]     cand;
    logic                 commit;
    logic [IDX_W-1:0]     commit_idx;
    logic [IDX_W-1:0]     suit_base;
    logic [1:0]           suit_c;
    logic                 unused_rand;

    assign mask_pad    = {{PAD_W{1'b1}}, mask_q};
    assign cand        = rand_in[IDX_W-1:0];
    assign unused_rand = ^rand_in[31:IDX_W];

    // Rank/suit of the committed index via a compare chain (no divider).
    always_comb begin
        suit_c    = 2'd0;
        suit_base = IDX_W'(0);
        if (commit_idx >= IDX_W'(39)) begin
            suit_c    = 2'd3;
            suit_base = IDX_W'(39);
        end else if (commit_idx >= IDX_W'(26)) begin
            suit_c    = 2'd2;
            suit_base = IDX_W'(26);
        end else if (commit_idx >= IDX_W'(13)) begin
            suit_c    = 2'd1;
            suit_base = IDX_W'(13);
        end
    end

    // Next-state, deck bookkeeping and output computation.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        left_d     = left_q;
        tries_d    = tries_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        rank_d     = rank_q;
        suit_d     = suit_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        commit     = 1'b0;
        commit_idx = IDX_W'(0);

        case (state_q)
            ST_IDLE: begin
                if (shuffle) begin
                    mask_d = '0;
                    left_d = IDX_W'(DECK_SIZE);
                end else if (deal_req) begin
                    if (left_q == IDX_W'(0)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_DRAW;
                        tries_d = TRY_W'(0);
                    end
                end
            end
            ST_DRAW: begin
                if (!mask_pad[cand]) begin
                    commit     = 1'b1;
                    commit_idx = cand;
                end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                    state_d = ST_PROBE;
                    ptr_d   = (cand < IDX_W'(DECK_SIZE)) ? cand
                                                         : IDX_W'(cand - IDX_W'(DECK_SIZE));
                end else begin
                    tries_d = TRY_W'(tries_q + TRY_W'(1));
                end
            end
            ST_PROBE: begin
                if (!mask_pad[ptr_q]) begin
                    commit     = 1'b1;
                    commit_idx = ptr_q;
                end else begin
                    ptr_d = (ptr_q == IDX_W'(DECK_SIZE - 1)) ? IDX_W'(0)
                                                             : IDX_W'(ptr_q + IDX_W'(1));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (commit) begin
            state_d            = ST_IDLE;
            mask_d[commit_idx] = 1'b1;
            if (left_q != IDX_W'(0)) begin
                left_d = IDX_W'(left_q - IDX_W'(1));
            end
            idx_d   = commit_idx;
            rank_d  = 4'(commit_idx - suit_base + IDX_W'(1));
            suit_d  = suit_c;
            valid_d = 1'b1;
        end

        ready_d = (state_d == ST_IDLE);
        empty_d = (left_d == IDX_W'(0));
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            left_q  <= IDX_W'(DECK_SIZE);
            tries_q <= TRY_W'(0);
            ptr_q   <= IDX_W'(0);
            idx_q   <= IDX_W'(0);
            rank_q  <= 4'd0;
            suit_q  <= 2'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            left_q  <= left_d;
            tries_q <= tries_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            rank_q  <= rank_d;
            suit_q  <= suit_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            empty_q <= empty_d;
        end
    end

    assign deal_ready = ready_q;
    assign card_valid = valid_q;
    assign card_idx   = idx_q;
    assign card_rank  = rank_q;
    assign card_suit  = suit_q;
    assign cards_left = left_q;
    assign deck_empty = empty_q;
    assign deal_err   = err_q;

endmodule

// File: tb/tb_card_dealer.sv
// Testbench for card_dealer: scoreboard of expected cards pushed at request
// time and popped when card_valid is observed.
module tb_card_dealer;

    localparam int MAX_TRIES = 8;
    localparam int LAT_MAX   = MAX_TRIES + 52 + 1;

    logic        clk;
    logic        rst_n;
    logic [31:0] rand_in;
    logic        shuffle;
    logic        deal_req;
    logic        deal_ready;
    logic        card_valid;
    logic [5:0]  card_idx;
    logic [3:0]  card_rank;
    logic [1:0]  card_suit;
    logic [5:0]  cards_left;
    logic        deck_empty;
    logic        deal_err;

    card_dealer #(.MAX_TRIES(MAX_TRIES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rand_in    (rand_in),
        .shuffle    (shuffle),
        .deal_req   (deal_req),
        .deal_ready (deal_ready),
        .card_valid (card_valid),
        .card_idx   (card_idx),
        .card_rank  (card_rank),
        .card_suit  (card_suit),
        .cards_left (cards_left),
        .deck_empty (deck_empty),
        .deal_err   (deal_err)
    );

    typedef struct {
        int idx;   // -1: any free card
        int left;
        int lat;   // 0: only the worst-case bound applies
        int req_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          err_cnt  = 0;
    int          model_left;
    bit          seen[52];
    bit          lfsr_mode;
    logic [31:0] const_rand;
    logic [31:0] lfsr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Free-running Galois LFSR, advanced away from the sampling edge.
    always @(negedge clk) lfsr <= {lfsr[30:0], 1'b0} ^ (lfsr[31] ? 32'h8020_0003 : 32'h0);
    assign rand_in = lfsr_mode ? lfsr : const_rand;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Output monitor: compare each card against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && deal_err) err_cnt++;
        if (rst_n && card_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                int   lat;
                e   = sb_q.pop_front();
                lat = cyc - e.req_cyc;
                if (e.idx >= 0) check("idx", card_idx, e.idx);
                check("idx_range", card_idx < 52, 1);
                check("rank", card_rank, card_idx % 13 + 1);
                check("suit", card_suit, card_idx / 13);
                check("cards_left", cards_left, e.left);
                check("deck_empty", deck_empty, e.left == 0);
                check("ready_with_valid", deal_ready, 1);
                if (e.lat > 0) check("latency", lat, e.lat);
                else           check("latency_bound", (lat >= 2) && (lat <= LAT_MAX), 1);
                if (card_idx < 52) begin
                    check("no_repeat", seen[card_idx], 0);
                    seen[card_idx] = 1'b1;
                end
            end
        end
    end

    task automatic deal(input int idx, input int lat, input bit shuf_mid);
        exp_t e;
        int   w;
        w = 0;
        while (!deal_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check("ready_timeout", 0, 1);
        model_left--;
        e.idx     = idx;
        e.left    = model_left;
        e.lat     = lat;
        e.req_cyc = cyc;
        sb_q.push_back(e);
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        if (shuf_mid) begin
            shuffle = 1'b1;
            repeat (3) @(negedge clk);
            shuffle = 1'b0;
        end
        w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb_q.size() != 0) begin
            check("deal_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        rst_n      = 1'b0;
        shuffle    = 1'b0;
        deal_req   = 1'b0;
        lfsr_mode  = 1'b0;
        const_rand = 32'h5;
        lfsr       = 32'hACE1_1234;
        model_left = 52;
        foreach (seen[i]) seen[i] = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cards_left", cards_left, 52);
        check("rst_deck_empty", deck_empty, 0);
        check("rst_deal_ready", deal_ready, 1);
        check("rst_card_valid", card_valid, 0);
        check("rst_deal_err", deal_err, 0);
        check("rst_card_idx", card_idx, 0);
        check("rst_card_rank", card_rank, 0);
        check("rst_card_suit", card_suit, 0);

        // Direct hit, then duplicate avoidance through the probe.
        deal(5, 2, 1'b0);
        check("hit_rank", card_rank, 6);
        deal(6, 11, 1'b0);

        // Out-of-range draws: probe starts at 63-52 = 11.
        const_rand = 32'h3F;
        @(negedge clk);
        deal(11, 10, 1'b0);
        check("probe_rank", card_rank, 12);
        check("probe_suit", card_suit, 0);

        // Shuffle during DRAW is ignored; probe skips taken 11 and lands on 12.
        deal(12, 11, 1'b1);
        check("left_after_mid_shuffle", cards_left, 48);

        // Six random deals make ten in total, then shuffle with deal_req.
        lfsr_mode = 1'b1;
        for (int i = 0; i < 6; i++) deal(-1, 0, 1'b0);
        check("left_before_shuffle", cards_left, 42);
        shuffle  = 1'b1;
        deal_req = 1'b1;
        @(negedge clk);
        shuffle  = 1'b0;
        deal_req = 1'b0;
        check("shuffle_left", cards_left, 52);
        check("shuffle_empty", deck_empty, 0);
        repeat (5) @(negedge clk);
        check("shuffle_no_deal", cards_left, 52);
        check("shuffle_ready", deal_ready, 1);
        model_left = 52;
        foreach (seen[i]) seen[i] = 1'b0;

        // Exhaust the deck.
        for (int i = 0; i < 52; i++) deal(-1, 0, 1'b0);
        cnt = 0;
        foreach (seen[i]) cnt += int'(seen[i]);
        check("all_cards_dealt", cnt, 52);
        check("exhaust_left", cards_left, 0);
        check("exhaust_empty", deck_empty, 1);

        // 53rd request: error pulse, no card.
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        check("err_pulse", deal_err, 1);
        check("err_no_valid", card_valid, 0);
        @(negedge clk);
        check("err_one_cycle", deal_err, 0);
        check("err_left", cards_left, 0);
        check("err_ready", deal_ready, 1);
        repeat (5) @(negedge clk);
        check("err_count", err_cnt, 1);
        check("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
